// File: rtl/rr_arb_enc4_if.sv
// Request/grant bundle between the four requesters and the round-robin arbiter.
// Handshake: req[i] is a level request held high while agent i needs the resource; gnt/gnt_idx/gnt_valid are registered and describe the current owner, with no combinational path from req.
interface rr_arb_enc4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arb_enc4.sv
// Four-requester round-robin arbiter with one-hot and encoded grant, plus a
// hold limit that forces rotation when an owner keeps the grant too long.
module rr_arb_enc4 #(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  rr_arb_enc4_if.slave  bus,
  output logic          dbg_fsm_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] others;
  logic [1:0] ptr_next;

  // First set bit of v scanning p, p+1, p+2, p+3 (mod 4); caller ensures v != 0.
  function automatic logic [1:0] pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (v[idx]) pick = idx;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    others   = bus.req & ~(4'b0001 << owner_q);
    ptr_next = owner_q + 2'd1;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = pick(bus.req, ptr_q);
          cnt_d   = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release and forced rotation share one path: hand off from owner+1.
        if (!bus.req[owner_q] || (cnt_q == HOLD_LIM && |others)) begin
          ptr_d = ptr_next;
          if (|others) begin
            owner_d = pick(others, ptr_next);
            cnt_d   = 8'd1;
          end else begin
            cnt_d   = 8'd0;
            state_d = IDLE;
          end
        end else if (cnt_q < HOLD_LIM) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt       = (state_q == GRANT) ? (4'b0001 << owner_q) : 4'b0000;
  assign bus.gnt_idx   = (state_q == GRANT) ? owner_q : 2'b00;
  assign bus.gnt_valid = (state_q == GRANT);
  assign dbg_fsm_o     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arb_enc4.sv
// Randomized and directed bench for rr_arb_enc4 with a queue-based scoreboard
// fed by an ownership-level reference model.
module tb_rr_arb_enc4;

  localparam int HOLD = 8;

  logic clk;
  logic rst;
  logic dbg_fsm;

  rr_arb_enc4_if bus ();

  rr_arb_enc4 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_fsm_o (dbg_fsm)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_owner;  // -1 when nobody owns the resource
  int m_ptr;
  int m_held;   // cycles the current owner has had the grant

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  function automatic int ref_pick(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++) begin
      if (v[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] model_outputs();
    logic [7:0] o;
    o = 8'h00;
    if (m_owner >= 0) begin
      o[7:4] = 4'(1 << m_owner);
      o[3:2] = 2'(m_owner);
      o[1]   = 1'b1;
      o[0]   = 1'b1;
    end
    return o;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = ref_pick(r, m_ptr);
        m_held  = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner] || (m_held >= HOLD && oth != 4'b0000)) begin
        m_ptr = (m_owner + 1) % 4;
        if (oth != 4'b0000) begin
          m_owner = ref_pick(oth, m_ptr);
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end else if (m_held < HOLD) begin
        m_held = m_held + 1;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] r);
    @(negedge clk);
    bus.req = r;
    model_step(r);
    exp_q.push_back(model_outputs());
  endtask

  task automatic check_zero(input string name);
    logic [7:0] act;
    act = {bus.gnt, bus.gnt_idx, bus.gnt_valid, dbg_fsm};
    n_checks++;
    if (act !== 8'h00) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b idx=%b valid=%b fsm=%b, want all zero",
               name, act[7:4], act[3:2], act[1], act[0]);
    end
  endtask

  // Assert reset between edges, confirm outputs clear without a clock edge.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst = 1'b1;
    bus.req = 4'b0000;
    #1;
    check_zero(name);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    logic [7:0] act;
    logic [7:0] exp;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {bus.gnt, bus.gnt_idx, bus.gnt_valid, dbg_fsm};
      n_checks++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL grant @%0t: got gnt=%b idx=%b valid=%b fsm=%b, want gnt=%b idx=%b valid=%b fsm=%b",
                 $time, act[7:4], act[3:2], act[1], act[0],
                 exp[7:4], exp[3:2], exp[1], exp[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r;
    int drained;
    rst = 1'b1;
    bus.req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Single requester: grant, hold past the limit alone, release.
    for (int i = 0; i < 21; i++) cycle(4'b0100);
    cycle(4'b0000);
    cycle(4'b0000);

    // Round-robin fairness with everyone requesting.
    async_reset("reset_before_rr");
    cycle(4'b1111);
    for (int i = 0; i < 8; i++) cycle(4'b1111 & ~(4'b0001 << (i % 4)));
    cycle(4'b0000);

    // Hold limit: agent 0 holds, agent 3 joins, then agent 3 releases.
    async_reset("reset_before_hold");
    cycle(4'b0001);
    cycle(4'b0001);
    for (int i = 0; i < 12; i++) cycle(4'b1001);
    cycle(4'b0001);
    cycle(4'b0001);
    cycle(4'b0000);

    // Pointer wrap: owner 3 releases while 0 and 1 request.
    async_reset("reset_before_wrap");
    cycle(4'b1000);
    cycle(4'b1000);
    cycle(4'b0011);
    cycle(4'b0011);
    cycle(4'b0000);

    // Same-cycle release of 1 and arrival of 2.
    async_reset("reset_before_simul");
    cycle(4'b0010);
    cycle(4'b0010);
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0000);

    // Reset mid-grant, then the first grant comes from ptr 0.
    async_reset("reset_before_midgrant");
    cycle(4'b0100);
    cycle(4'b0100);
    cycle(4'b0100);
    async_reset("reset_mid_grant");
    cycle(4'b1111);
    cycle(4'b1111);

    // Randomized traffic: mostly sticky requests with occasional flips.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 2) == 0) r = r ^ (4'b0001 << $urandom_range(0, 3));
      cycle(r);
      if ($urandom_range(0, 499) == 0) async_reset("reset_random");
    end

    drained = 0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    drained = (exp_q.size() == 0) ? 1 : 0;
    n_checks++;
    if (drained == 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d expected entries left, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_enc4.md
# rr_arb_enc4

Four-requester round-robin arbiter with encoded grant output, sequencing access to a single shared resource among four agents. It produces a one-hot grant plus the 2-bit encoded index of the current owner (MSB/LSB in the same bit order as the team's 4:2 encoder), so downstream muxes select directly on the index. A per-grant hold limit prevents one requester from starving the others. It sits between the request sources and the shared datapath's select logic.

## Interface
- HOLD_MAX, 8: maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..255.

- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req  input  4  request bits; req[i] high = agent i wants the resource; held high for as long as it needs it.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- gnt_idx  output  2  encoded owner index (gnt_idx[1]=a, gnt_idx[0]=b); 0 when no owner.
- gnt_valid  output  1  high while an owner exists (equals |gnt).

## Operation
- Internal state: fsm {IDLE, GRANT}, owner[1:0], ptr[1:0] (round-robin start point), cnt[7:0] (hold counter).
- Pick function: first set bit of a request vector scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE, any req set: owner <= pick(req); gnt <= onehot(owner); gnt_idx <= owner; gnt_valid <= 1; cnt <= 1; -> GRANT.
- IDLE, req == 0: stay; outputs zero.
- GRANT, release (req[owner] == 0): ptr <= owner+1. Let others = req with bit owner cleared. If others != 0, grant pick(others) using the new ptr in the same edge (back-to-back, no dead cycle), cnt <= 1, stay GRANT. Otherwise outputs zero, -> IDLE.
- GRANT, forced rotation (req[owner] == 1, cnt == HOLD_MAX, others != 0): identical to release with others. The preempted agent is not granted again until the scan passes it.
- GRANT, req[owner] == 1 otherwise: hold; cnt <= cnt+1, saturating at HOLD_MAX. If others == 0 the owner holds indefinitely. When another request arrives with cnt already at HOLD_MAX, rotation occurs at the next edge.
- ptr advances only on release or rotation, never on the initial grant from IDLE.
- Exactly one gnt bit is ever high. gnt_idx always equals encode(gnt).

## Timing
- Reset: gnt=0000, gnt_idx=00, gnt_valid=0, fsm=IDLE, ptr=0, owner=0, cnt=0. Reset takes effect immediately and asynchronously, including mid-grant. After reset deasserts, the first grant is picked from ptr=0.
- Latency: req sampled high at edge N in IDLE -> gnt high after edge N (visible in cycle N+1).
- Release latency: owner drops req before edge N -> gnt moves to the next owner (or to zero) after edge N.
- All outputs are registered; no combinational path from req to outputs.
- Simultaneous requests: resolved only by ptr order, never by index.
- Release and a new request in the same cycle: the new request is eligible for the same-edge handoff.
- Owner drops req exactly at cnt == HOLD_MAX: treated as a release (identical result).
- Wrap-around: ptr = 3+1 wraps to 0; cnt saturates and never wraps.

## Test plan
- Reset mid-grant: owner=2 holding, assert rst asynchronously between edges -> gnt=0000, gnt_idx=00, gnt_valid=0 immediately; after release, req=1111 -> gnt=0001, idx=00.
- Single requester: req=0100 from IDLE -> gnt=0100, idx=10 one edge later. Hold for 20 cycles with no others -> grant is retained. Drop req -> gnt=0000 after the next edge.
- Round-robin fairness: req=1111 held, each owner releases after 1 cycle and reasserts. Grant sequence from reset is 0, 1, 2, 3, 0 (idx 00, 01, 10, 11, 00) with no dead cycles.
- Hold limit, HOLD_MAX=8: agent 0 holds req continuously and req[3] rises at cycle 2 -> gnt moves to 1000 exactly 8 grant cycles after agent 0's grant. Agent 0 is re-granted only after agent 3 releases.
- Wrap pointer: owner 3 releases while req=0011 -> next grant=0001 (ptr wrapped to 0), not 0010.
- Simultaneous release/request: owner 1 drops req in the same cycle that req[2] rises -> gnt=0100 after that edge, with gnt_valid staying 1 throughout.
